// File: rtl/mem_wb_if.sv
// MEM -> WB bundle: MEM-stage instruction fields in, regfile write port and fault flag out.
// The slave modport is the write-back stage; the master modport is whoever drives MEM results.
interface mem_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              mem_valid;
    logic              mem_wreg;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_load;
    logic [2:0]        mem_funct3;
    logic [1:0]        mem_addr_lo;

    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_exc;

    modport master (
        output mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_load, mem_funct3, mem_addr_lo,
        input  wb_valid, wb_we, wb_waddr, wb_wdata, wb_exc
    );

    modport slave (
        input  mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_load, mem_funct3, mem_addr_lo,
        output wb_valid, wb_we, wb_waddr, wb_wdata, wb_exc
    );
endinterface

// File: rtl/mem_wb.sv
// Write-back pipeline register: load byte/halfword extraction, misaligned/illegal load detection.
// Optional retire counter output wb_retired enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush_i,
`ifdef MEM_WB_RETIRE_CNT_EN
    output logic [63:0] wb_retired,
`endif
    mem_wb_if.slave     bus
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic              valid_q, valid_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              exc_q,   exc_d;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;
    logic              fault;
    logic              capture;

    assign byte_sel = bus.mem_wdata[8*bus.mem_addr_lo +: 8];
    assign half_sel = bus.mem_wdata[16*bus.mem_addr_lo[1] +: 16];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_data = bus.mem_wdata;
        fault     = 1'b0;
        if (bus.mem_load) begin
            unique case (bus.mem_funct3)
                F3_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
                F3_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
                F3_LH: begin
                    load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
                    fault     = bus.mem_addr_lo[0];
                end
                F3_LHU: begin
                    load_data = {{(DATA_W-16){1'b0}}, half_sel};
                    fault     = bus.mem_addr_lo[0];
                end
                F3_LW:   fault = |bus.mem_addr_lo;
                default: fault = 1'b1;
            endcase
        end
    end

    assign capture = rdy && !flush_i && bus.mem_valid;

    always_comb begin
        valid_d = 1'b0;
        we_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        exc_d   = 1'b0;
        if (!rdy) begin
            valid_d = valid_q;
            we_d    = we_q;
            waddr_d = waddr_q;
            wdata_d = wdata_q;
            exc_d   = exc_q;
        end else if (capture) begin
            valid_d = 1'b1;
            waddr_d = bus.mem_waddr;
            // A faulting load keeps its destination for trap reporting but never writes.
            if (fault) begin
                exc_d = 1'b1;
            end else begin
                we_d    = bus.mem_wreg;
                wdata_d = load_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            exc_q   <= exc_d;
        end
    end

    assign bus.wb_valid = valid_q;
    assign bus.wb_we    = we_q;
    assign bus.wb_waddr = waddr_q;
    assign bus.wb_wdata = wdata_q;
    assign bus.wb_exc   = exc_q;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (capture && !fault) retired_d = retired_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign wb_retired = retired_q;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: table-driven capture/extraction vectors plus
// hand-written stall, flush, fault-pulse, async-reset and (optional) retire-count sequences.
module tb_mem_wb;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush_i;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] wb_retired;
`endif

    mem_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush_i    (flush_i),
`ifdef MEM_WB_RETIRE_CNT_EN
        .wb_retired (wb_retired),
`endif
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        load;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_exc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wb(input string name, input logic v, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd, input logic ex);
        check({name, ".valid"}, {63'd0, bus.wb_valid}, {63'd0, v});
        check({name, ".we"},    {63'd0, bus.wb_we},    {63'd0, we});
        check({name, ".waddr"}, {59'd0, bus.wb_waddr}, {59'd0, wa});
        check({name, ".wdata"}, {32'd0, bus.wb_wdata}, {32'd0, wd});
        check({name, ".exc"},   {63'd0, bus.wb_exc},   {63'd0, ex});
    endtask

    task automatic drive(input logic v, input logic wreg, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ld, input logic [2:0] f3,
                         input logic [1:0] lo);
        bus.mem_valid   = v;
        bus.mem_wreg    = wreg;
        bus.mem_waddr   = wa;
        bus.mem_wdata   = wd;
        bus.mem_load    = ld;
        bus.mem_funct3  = f3;
        bus.mem_addr_lo = lo;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] W = 32'h80FF_7F01;

    initial begin
        vecs.push_back('{"alu",      1, 5'd5,  32'h1234_5678, 0, 3'b000, 2'd0, 1, 32'h1234_5678, 0});
        vecs.push_back('{"lb_a3",    1, 5'd6,  W, 1, 3'b000, 2'd3, 1, 32'hFFFF_FF80, 0});
        vecs.push_back('{"lbu_a3",   1, 5'd7,  W, 1, 3'b100, 2'd3, 1, 32'h0000_0080, 0});
        vecs.push_back('{"lh_a2",    1, 5'd8,  W, 1, 3'b001, 2'd2, 1, 32'hFFFF_80FF, 0});
        vecs.push_back('{"lhu_a0",   1, 5'd9,  W, 1, 3'b101, 2'd0, 1, 32'h0000_7F01, 0});
        vecs.push_back('{"lb_a0",    1, 5'd10, W, 1, 3'b000, 2'd0, 1, 32'h0000_0001, 0});
        vecs.push_back('{"lb_a1",    1, 5'd11, W, 1, 3'b000, 2'd1, 1, 32'h0000_007F, 0});
        vecs.push_back('{"lb_a2",    1, 5'd12, W, 1, 3'b000, 2'd2, 1, 32'hFFFF_FFFF, 0});
        vecs.push_back('{"lbu_a2",   1, 5'd13, W, 1, 3'b100, 2'd2, 1, 32'h0000_00FF, 0});
        vecs.push_back('{"lh_a0",    1, 5'd14, W, 1, 3'b001, 2'd0, 1, 32'h0000_7F01, 0});
        vecs.push_back('{"lhu_a2",   1, 5'd15, W, 1, 3'b101, 2'd2, 1, 32'h0000_80FF, 0});
        vecs.push_back('{"lw_a0",    1, 5'd16, W, 1, 3'b010, 2'd0, 1, W, 0});
        vecs.push_back('{"lw_a1",    1, 5'd17, W, 1, 3'b010, 2'd1, 0, 32'h0, 1});
        vecs.push_back('{"lw_a2",    1, 5'd18, W, 1, 3'b010, 2'd2, 0, 32'h0, 1});
        vecs.push_back('{"lh_a1",    1, 5'd19, W, 1, 3'b001, 2'd1, 0, 32'h0, 1});
        vecs.push_back('{"lhu_a3",   1, 5'd20, W, 1, 3'b101, 2'd3, 0, 32'h0, 1});
        vecs.push_back('{"ill_011",  1, 5'd21, W, 1, 3'b011, 2'd0, 0, 32'h0, 1});
        vecs.push_back('{"ill_110",  1, 5'd22, W, 1, 3'b110, 2'd0, 0, 32'h0, 1});
        vecs.push_back('{"ill_111",  1, 5'd23, W, 1, 3'b111, 2'd0, 0, 32'h0, 1});
        vecs.push_back('{"x0_write", 1, 5'd0,  32'hDEAD_BEEF, 0, 3'b000, 2'd0, 1, 32'hDEAD_BEEF, 0});
        vecs.push_back('{"no_wreg",  0, 5'd24, W, 1, 3'b010, 2'd0, 0, W, 0});
        vecs.push_back('{"alu_b2b",  1, 5'd31, 32'h0BAD_F00D, 0, 3'b111, 2'd3, 1, 32'h0BAD_F00D, 0});

        rst = 1'b1; rdy = 1'b1; flush_i = 1'b0;
        drive(1, 1, 5'd3, 32'hFFFF_FFFF, 0, 3'b000, 2'd0);
        tick();
        check_wb("reset", 0, 0, 5'd0, 32'h0, 0);
        tick();
        check_wb("reset_hold", 0, 0, 5'd0, 32'h0, 0);
        rst = 1'b0;
        drive(0, 0, 5'd0, 32'h0, 0, 3'b000, 2'd0);
        tick();
        check_wb("idle_bubble", 0, 0, 5'd0, 32'h0, 0);

        foreach (vecs[i]) begin
            drive(1, vecs[i].wreg, vecs[i].waddr, vecs[i].wdata, vecs[i].load, vecs[i].f3, vecs[i].lo);
            tick();
            check_wb(vecs[i].name, 1, vecs[i].e_we, vecs[i].waddr, vecs[i].e_wdata, vecs[i].e_exc);
        end

        // Fault pulse lasts one cycle and clears on the following bubble.
        drive(1, 1, 5'd4, W, 1, 3'b010, 2'd1);
        tick();
        check_wb("fault_pulse", 1, 0, 5'd4, 32'h0, 1);
        drive(0, 1, 5'd4, W, 1, 3'b010, 2'd1);
        tick();
        check_wb("fault_then_bubble", 0, 0, 5'd0, 32'h0, 0);

        // Stall: outputs frozen for 3 cycles while MEM inputs change.
        drive(1, 1, 5'd9, 32'hCAFE_0001, 0, 3'b000, 2'd0);
        tick();
        check_wb("pre_stall", 1, 1, 5'd9, 32'hCAFE_0001, 0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1, 5'(i + 1), 32'h1111_0000 + 32'(i), 1, 3'(i + 3), 2'(i));
            flush_i = (i == 1);
            tick();
            check_wb($sformatf("stall%0d", i), 1, 1, 5'd9, 32'hCAFE_0001, 0);
        end
        flush_i = 1'b0;

        // A stalled fault keeps its exc pulse asserted.
        rdy = 1'b1;
        drive(1, 1, 5'd12, W, 1, 3'b110, 2'd0);
        tick();
        rdy = 1'b0;
        drive(1, 1, 5'd2, 32'h5, 0, 3'b000, 2'd0);
        tick();
        check_wb("stall_exc_hold", 1, 0, 5'd12, 32'h0, 1);
        rdy = 1'b1;
        tick();
        check_wb("stall_release", 1, 1, 5'd2, 32'h5, 0);

        // Flush kills a valid ALU op.
        flush_i = 1'b1;
        drive(1, 1, 5'd7, 32'h7777_7777, 0, 3'b000, 2'd0);
        tick();
        check_wb("flush", 0, 0, 5'd0, 32'h0, 0);
        flush_i = 1'b0;

        // Async reset mid-cycle drops the live write before any clock edge.
        drive(1, 1, 5'd25, 32'hABCD_1234, 0, 3'b000, 2'd0);
        tick();
        check_wb("pre_async", 1, 1, 5'd25, 32'hABCD_1234, 0);
        #2 rst = 1'b1;
        #1;
        check_wb("async_rst", 0, 0, 5'd0, 32'h0, 0);
        tick();
        check_wb("async_rst_edge", 0, 0, 5'd0, 32'h0, 0);
        #2 rst = 1'b0;
        drive(1, 1, 5'd26, 32'h0000_BEEF, 0, 3'b000, 2'd0);
        tick();
        check_wb("post_rst_capture", 1, 1, 5'd26, 32'h0000_BEEF, 0);

`ifdef MEM_WB_RETIRE_CNT_EN
        #2 rst = 1'b1;
        #1;
        check("retired_reset", wb_retired, 64'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3 || i == 8)
                drive(0, 1, 5'd1, 32'(i), 0, 3'b000, 2'd0);
            else if (i == 5)
                drive(1, 1, 5'd1, W, 1, 3'b001, 2'd1);
            else
                drive(1, 1, 5'(i), 32'(i), 0, 3'b000, 2'd0);
            tick();
        end
        check("retired_count", wb_retired, 64'd10);
        rdy = 1'b0;
        drive(1, 1, 5'd1, 32'h1, 0, 3'b000, 2'd0);
        tick();
        check("retired_stall_hold", wb_retired, 64'd10);
        rdy = 1'b1;
        flush_i = 1'b1;
        tick();
        check("retired_flush", wb_retired, 64'd10);
        flush_i = 1'b0;
        tick();
        check("retired_inc", wb_retired, 64'd11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
